// File: rtl/bram_read_stream_if.sv
// Handshake bundle between the read sequencer, the BRAM wrapper and the stream consumer.
// slave = the sequencer itself, master = the surrounding logic that drives commands, BRAM data and ready.
interface bram_read_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 9
);
  logic                  i_cmd_v;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [LEN_WIDTH-1:0]  i_cmd_len;
  logic                  o_cmd_r;
  logic                  o_re;
  logic [ADDR_WIDTH-1:0] o_ra;
  logic [DATA_WIDTH-1:0] i_rd;
  logic                  o_v;
  logic [DATA_WIDTH-1:0] o_d;
  logic                  i_r;
  logic                  o_busy;

  modport slave (
    input  i_cmd_v, i_cmd_addr, i_cmd_len, i_rd, i_r,
    output o_cmd_r, o_re, o_ra, o_v, o_d, o_busy
  );

  modport master (
    output i_cmd_v, i_cmd_addr, i_cmd_len, i_rd, i_r,
    input  o_cmd_r, o_re, o_ra, o_v, o_d, o_busy
  );
endinterface

// File: rtl/bram_read_stream.sv
// Burst read sequencer for a fixed-latency BRAM, with a credit-guarded output FIFO
// that absorbs the read latency and presents the data as a valid/ready stream.
//
// state | meaning
// IDLE  | command ready; accepts a burst (len=0 is accepted and dropped)
// READ  | issuing one read per cycle while credit is available
module bram_read_stream #(
  parameter int DATA_WIDTH   = 64,
  parameter int RAM_DEPTH    = 512,
  parameter int ADDR_WIDTH   = $clog2(RAM_DEPTH),
  parameter int LEN_WIDTH    = 9,
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic               clk2x,
  input logic               reset,
  bram_read_stream_if.slave bus
);
  // FIFO_DEPTH must be a power of two so the FIFO pointers wrap naturally.
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, READ} state_t;

  state_t                state;
  logic                  cmd_r;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [CW-1:0]         credit;
  logic [CW-1:0]         count;
  logic [BRAM_LATENCY-1:0] vpipe;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  issue;
  logic                  wr;
  logic                  pop;

  // Issue uses the registered credit only; a pop in the same cycle frees a slot next cycle.
  assign issue = (state == READ) && (remaining != '0) && (credit < CREDIT_MAX);
  assign wr    = vpipe[BRAM_LATENCY-1];
  assign pop   = (count != '0) && bus.i_r;

  always_ff @(posedge clk2x or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_r     <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_r <= 1'b1;
          if (bus.i_cmd_v && cmd_r) begin
            ptr       <= bus.i_cmd_addr;
            remaining <= bus.i_cmd_len;
            if (bus.i_cmd_len != '0) begin
              state <= READ;
              cmd_r <= 1'b0;
            end
          end
        end
        READ: begin
          if (issue) begin
            ptr       <= ptr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state <= IDLE;
              cmd_r <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cmd_r <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk2x or negedge reset) begin
    if (!reset) begin
      credit <= '0;
      count  <= '0;
      vpipe  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      credit <= credit + CW'(issue) - CW'(pop);
      count  <= count + CW'(wr) - CW'(pop);
      vpipe  <= BRAM_LATENCY'({vpipe, issue});
      if (wr) begin
        mem[wr_ptr] <= bus.i_rd;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign bus.o_cmd_r = cmd_r;
  assign bus.o_re    = issue;
  assign bus.o_ra    = ptr;
  assign bus.o_v     = (count != '0);
  assign bus.o_d     = mem[rd_ptr];
  assign bus.o_busy  = (state == READ) || (|vpipe) || (count != '0);
endmodule

// File: tb/tb_bram_read_stream.sv
// Randomized-stall bench for bram_read_stream against a queue-based model of the
// accepted bursts, with a two-cycle BRAM model on the read side.
module tb_bram_read_stream;
  localparam int DW = 64, DEPTH = 512, AW = 9, LW = 9, FD = 4;

  logic clk2x = 1'b0;
  logic reset;
  always #5 clk2x = ~clk2x;

  bram_read_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  bram_read_stream #(
    .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .BRAM_LATENCY(2), .FIFO_DEPTH(FD)
  ) dut (
    .clk2x(clk2x),
    .reset(reset),
    .bus  (bus)
  );

  // BRAM model: data for a read issued in cycle t is on i_rd in cycle t+2
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] st1;
  always @(posedge clk2x) begin
    if (bus.o_re) st1 <= ram[bus.o_ra];
    bus.i_rd <= st1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic [DW-1:0] last_pop_data;
  int issued, popped, cyc;
  int n_re, n_pop, n_v, first_re, last_re, first_pop, last_pop, acc_cyc;
  bit mon, rand_r;

  task automatic clear_model();
    exp_addr.delete();
    exp_data.delete();
    issued = 0;
    popped = 0;
  endtask

  task automatic clear_stats();
    n_re = 0; n_pop = 0; n_v = 0;
    first_re = -1; last_re = -1; first_pop = -1; last_pop = -1; acc_cyc = -1;
  endtask

  // One cycle: check this cycle's outputs against the model, then advance to the next negedge.
  task automatic step();
    logic [AW-1:0] a;
    if (rand_r) bus.i_r = 1'($urandom_range(0, 1));
    if (mon) begin
      check("busy", bus.o_busy, exp_data.size() != 0);
      check("cmd_r", bus.o_cmd_r, exp_addr.size() == 0);
      if (bus.o_re) begin
        if (exp_addr.size() == 0) check("spurious_re", bus.o_re, 0);
        else check("ra", bus.o_ra, exp_addr.pop_front());
        check("credit_free", (issued - popped) < FD, 1);
        issued++;
        n_re++;
        if (first_re < 0) first_re = cyc;
        last_re = cyc;
      end
      if (bus.o_v) n_v++;
      if (bus.o_v && bus.i_r) begin
        if (exp_data.size() == 0) check("spurious_pop", bus.o_v, 0);
        else check("data", bus.o_d, exp_data.pop_front());
        last_pop_data = bus.o_d;
        popped++;
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (bus.i_cmd_v && bus.o_cmd_r) begin
        acc_cyc = cyc;
        for (int i = 0; i < int'(bus.i_cmd_len); i++) begin
          a = AW'(int'(bus.i_cmd_addr) + i);
          exp_addr.push_back(a);
          exp_data.push_back(ram[a]);
        end
      end
    end
    @(negedge clk2x);
    cyc++;
  endtask

  task automatic send_cmd(input int addr, input int len);
    int t = 0;
    while (!bus.o_cmd_r && t < 200) begin
      step();
      t++;
    end
    check("cmd_r_wait", bus.o_cmd_r, 1);
    bus.i_cmd_addr = AW'(addr);
    bus.i_cmd_len  = LW'(len);
    bus.i_cmd_v    = 1'b1;
    step();
    bus.i_cmd_v    = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_data.size() != 0 || bus.o_busy) && t < 3000) begin
      step();
      t++;
    end
    check("drain_left", exp_data.size(), 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_cmd_r"}, bus.o_cmd_r, 0);
    check({pfx, "_re"},    bus.o_re, 0);
    check({pfx, "_ra"},    bus.o_ra, 0);
    check({pfx, "_v"},     bus.o_v, 0);
    check({pfx, "_d"},     bus.o_d, 0);
    check({pfx, "_busy"},  bus.o_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    bus.i_cmd_v = 1'b0; bus.i_cmd_addr = '0; bus.i_cmd_len = '0; bus.i_r = 1'b0;
    mon = 0; rand_r = 0; cyc = 0; last_pop_data = '0;
    clear_model();
    clear_stats();

    // reset state and release
    reset = 1'b0;
    repeat (3) @(negedge clk2x);
    check_zero("rst");
    reset = 1'b1;
    @(negedge clk2x);
    check("cmd_r_post_rst", bus.o_cmd_r, 1);
    check("busy_post_rst", bus.o_busy, 0);
    mon = 1;

    // reset mid-burst with two reads in flight
    clear_stats();
    bus.i_r = 1'b1;
    send_cmd(100, 8);
    step();
    step();
    check("inflight", issued - popped, 2);
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    mon = 0;
    clear_model();
    @(negedge clk2x);
    @(negedge clk2x);
    reset = 1'b1;
    @(negedge clk2x);
    check("cmd_r_rel", bus.o_cmd_r, 1);
    mon = 1;
    clear_stats();
    repeat (8) step();
    check("no_v_after_rst", n_v, 0);

    // simple burst
    clear_stats();
    send_cmd(10, 8);
    drain();
    check("sb_n_re", n_re, 8);
    check("sb_first_re", first_re, acc_cyc + 1);
    check("sb_last_re", last_re, acc_cyc + 8);
    check("sb_n_pop", n_pop, 8);
    check("sb_first_v", first_pop, acc_cyc + 4);
    check("sb_last_v", last_pop, acc_cyc + 11);

    // address wrap
    clear_stats();
    send_cmd(510, 4);
    drain();
    check("wr_n_pop", n_pop, 4);
    check("wr_last_d", last_pop_data, 1);

    // backpressure
    clear_stats();
    bus.i_r = 1'b0;
    send_cmd(200, 16);
    repeat (20) step();
    check("bp_issued", n_re, FD);
    check("bp_re_low", bus.o_re, 0);
    bus.i_r = 1'b1;
    drain();
    check("bp_n_pop", n_pop, 16);

    // random stall over back-to-back bursts including len=0
    clear_stats();
    rand_r = 1;
    send_cmd(300, 5);
    send_cmd(40, 0);
    send_cmd(60, 7);
    drain();
    rand_r = 0;
    bus.i_r = 1'b1;
    check("rs_n_re", n_re, 12);
    check("rs_n_pop", n_pop, 12);

    // maximum length, full throughput
    clear_stats();
    send_cmd(0, 511);
    drain();
    check("mx_n_re", n_re, 511);
    check("mx_first_re", first_re, acc_cyc + 1);
    check("mx_last_re", last_re, acc_cyc + 511);
    check("mx_n_pop", n_pop, 511);
    check("mx_first_v", first_pop, acc_cyc + 4);
    check("mx_span", last_pop - first_pop, 510);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
